// File: rtl/ssrv_dmem_rmw_bridge_pkg.sv
// Shared types for the LSU-to-word-memory bridge: scr1 memif enums, bridge FSM states
// and the alignment rule applied to incoming core requests.
package ssrv_dmem_rmw_bridge_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [2:0] {
    SSRV_RMW_IDLE,
    SSRV_RMW_RD_REQ,
    SSRV_RMW_RD_RESP,
    SSRV_RMW_WR_REQ,
    SSRV_RMW_WR_RESP,
    SSRV_RMW_RESP
  } type_ssrv_rmw_state_e;

  // The ERROR width is never a legal access, whatever the address.
  function automatic logic ssrv_rmw_misaligned(input type_scr1_mem_width_e width,
                                               input logic [1:0] offset);
    case (width)
      SCR1_MEM_WIDTH_BYTE:  return 1'b0;
      SCR1_MEM_WIDTH_HWORD: return offset[0];
      SCR1_MEM_WIDTH_WORD:  return |offset;
      default:              return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ssrv_dmem_rmw_bridge_if.sv
// scr1-style memory request/response bus; the bridge is a slave to the core and a
// master to the word memory.
interface ssrv_dmem_rmw_bridge_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  import ssrv_dmem_rmw_bridge_pkg::*;

  logic                 req;
  type_scr1_mem_cmd_e   cmd;
  type_scr1_mem_width_e width;
  logic [AWIDTH-1:0]    addr;
  logic [DWIDTH-1:0]    wdata;
  logic                 req_ack;
  logic [DWIDTH-1:0]    rdata;
  type_scr1_mem_resp_e  resp;

  modport master (output req, cmd, width, addr, wdata, input req_ack, rdata, resp);
  modport slave  (input req, cmd, width, addr, wdata, output req_ack, rdata, resp);

endinterface

// File: rtl/ssrv_lane_merge.sv
// Byte/halfword lane handling within a 32-bit word: inserts a right-aligned lane for
// read-modify-write and extracts a right-aligned, zero-extended lane for reads.
module ssrv_lane_merge
  import ssrv_dmem_rmw_bridge_pkg::*;
(
  input  logic [31:0]          word,
  input  logic [31:0]          lane_data,
  input  logic [1:0]           offset,
  input  type_scr1_mem_width_e width,
  output logic [31:0]          merged,
  output logic [31:0]          extracted
);

  logic [31:0] mask;
  logic [4:0]  shamt;

  always_comb begin
    shamt = {offset, 3'b000};
    case (width)
      SCR1_MEM_WIDTH_BYTE:  mask = 32'h0000_00FF;
      SCR1_MEM_WIDTH_HWORD: mask = 32'h0000_FFFF;
      default:              mask = 32'hFFFF_FFFF;
    endcase
    merged    = (word & ~(mask << shamt)) | ((lane_data & mask) << shamt);
    extracted = (word >> shamt) & mask;
  end

endmodule

// File: rtl/ssrv_dmem_rmw_bridge.sv
// Converts core byte/halfword/word requests into word-aligned memory accesses,
// using read-modify-write for sub-word stores and a per-state timeout.
module ssrv_dmem_rmw_bridge
  import ssrv_dmem_rmw_bridge_pkg::*;
#(
  parameter int AWIDTH         = 32,
  parameter int DWIDTH         = 32,
  parameter int TIMEOUT_CYCLES = 64
)(
  input  logic                   clk,
  input  logic                   rst,
  ssrv_dmem_rmw_bridge_if.slave  core,
  ssrv_dmem_rmw_bridge_if.master mem
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  type_ssrv_rmw_state_e state, state_next;
  type_scr1_mem_resp_e  resp_q, resp_next;
  type_scr1_mem_cmd_e   cmd_q;
  type_scr1_mem_width_e width_q;
  logic [DWIDTH-1:0]    wdata_q;
  logic [1:0]           offset_q;
  logic [AWIDTH-1:0]    mem_addr_q;
  logic [DWIDTH-1:0]    mem_wdata_q;
  logic [DWIDTH-1:0]    rdata_q;
  logic [CNT_W-1:0]     tmo_cnt;
  logic                 accept, timed_out, fin, load_rdata, load_merge;
  logic [DWIDTH-1:0]    merged, extracted;

  ssrv_lane_merge u_lane_merge (
    .word      (mem.rdata),
    .lane_data (wdata_q),
    .offset    (offset_q),
    .width     (width_q),
    .merged    (merged),
    .extracted (extracted)
  );

  assign accept       = (state == SSRV_RMW_IDLE) && core.req;
  assign timed_out    = (tmo_cnt == TMO_LAST);
  assign core.req_ack = accept;
  assign core.rdata   = rdata_q;
  assign core.resp    = (state == SSRV_RMW_RESP) ? resp_q : SCR1_MEM_RESP_NOTRDY;
  assign mem.req      = (state == SSRV_RMW_RD_REQ) || (state == SSRV_RMW_WR_REQ);
  assign mem.cmd      = ((state == SSRV_RMW_WR_REQ) || (state == SSRV_RMW_WR_RESP))
                        ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
  assign mem.width    = SCR1_MEM_WIDTH_WORD;
  assign mem.addr     = mem_addr_q;
  assign mem.wdata    = mem_wdata_q;

  always_comb begin
    state_next = state;
    resp_next  = resp_q;
    fin        = 1'b0;
    load_rdata = 1'b0;
    load_merge = 1'b0;
    case (state)
      SSRV_RMW_IDLE: begin
        if (core.req) begin
          if (ssrv_rmw_misaligned(core.width, core.addr[1:0])) begin
            state_next = SSRV_RMW_RESP;
            resp_next  = SCR1_MEM_RESP_RDY_ER;
          end else if (core.cmd == SCR1_MEM_CMD_WR && core.width == SCR1_MEM_WIDTH_WORD) begin
            state_next = SSRV_RMW_WR_REQ;
          end else begin
            state_next = SSRV_RMW_RD_REQ;
          end
        end
      end
      SSRV_RMW_RD_REQ, SSRV_RMW_RD_RESP: begin
        // A response arriving with the accept is consumed without visiting RD_RESP.
        fin = ((state == SSRV_RMW_RD_RESP) || mem.req_ack) && (mem.resp != SCR1_MEM_RESP_NOTRDY);
        if (fin) begin
          if (mem.resp == SCR1_MEM_RESP_RDY_ER) begin
            state_next = SSRV_RMW_RESP;
            resp_next  = SCR1_MEM_RESP_RDY_ER;
          end else if (cmd_q == SCR1_MEM_CMD_RD) begin
            state_next = SSRV_RMW_RESP;
            resp_next  = SCR1_MEM_RESP_RDY_OK;
            load_rdata = 1'b1;
          end else begin
            state_next = SSRV_RMW_WR_REQ;
            load_merge = 1'b1;
          end
        end else if ((state == SSRV_RMW_RD_REQ) && mem.req_ack) begin
          state_next = SSRV_RMW_RD_RESP;
        end else if (timed_out) begin
          state_next = SSRV_RMW_RESP;
          resp_next  = SCR1_MEM_RESP_RDY_ER;
        end
      end
      SSRV_RMW_WR_REQ, SSRV_RMW_WR_RESP: begin
        fin = ((state == SSRV_RMW_WR_RESP) || mem.req_ack) && (mem.resp != SCR1_MEM_RESP_NOTRDY);
        if (fin) begin
          state_next = SSRV_RMW_RESP;
          resp_next  = (mem.resp == SCR1_MEM_RESP_RDY_ER) ? SCR1_MEM_RESP_RDY_ER
                                                          : SCR1_MEM_RESP_RDY_OK;
        end else if ((state == SSRV_RMW_WR_REQ) && mem.req_ack) begin
          state_next = SSRV_RMW_WR_RESP;
        end else if (timed_out) begin
          state_next = SSRV_RMW_RESP;
          resp_next  = SCR1_MEM_RESP_RDY_ER;
        end
      end
      SSRV_RMW_RESP: state_next = SSRV_RMW_IDLE;
      default:       state_next = SSRV_RMW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SSRV_RMW_IDLE;
      resp_q      <= SCR1_MEM_RESP_NOTRDY;
      tmo_cnt     <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state  <= state_next;
      resp_q <= resp_next;
      // Every state change restarts the wait budget for the new state.
      if (state_next != state)
        tmo_cnt <= '0;
      else if (state != SSRV_RMW_IDLE)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (accept) begin
        mem_addr_q <= {core.addr[AWIDTH-1:2], 2'b00};
        if (core.cmd == SCR1_MEM_CMD_WR && core.width == SCR1_MEM_WIDTH_WORD)
          mem_wdata_q <= core.wdata;
      end
      if (load_merge) mem_wdata_q <= merged;
      if (load_rdata) rdata_q     <= extracted;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_q    <= core.cmd;
      width_q  <= core.width;
      wdata_q  <= core.wdata;
      offset_q <= core.addr[1:0];
    end
  end

endmodule

// File: tb/tb_ssrv_dmem_rmw_bridge.sv
// Directed bench for ssrv_dmem_rmw_bridge with a small word memory that can answer in
// the accept cycle, one cycle later, never, or with an error.
module tb_ssrv_dmem_rmw_bridge;
  import ssrv_dmem_rmw_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ssrv_dmem_rmw_bridge_if #(.AWIDTH(32), .DWIDTH(32)) core_bus ();
  ssrv_dmem_rmw_bridge_if #(.AWIDTH(32), .DWIDTH(32)) mem_bus ();

  ssrv_dmem_rmw_bridge #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (core_bus),
    .mem  (mem_bus)
  );

  // Memory model
  logic [31:0] mem_arr [0:1023];
  logic        ack_en = 1'b1, resp_en = 1'b1, split = 1'b0, err_en = 1'b0;
  logic        pend = 1'b0;
  logic        poke_en = 1'b0;
  logic [31:0] poke_addr = '0, poke_data = '0;
  int          rd_cnt = 0, wr_cnt = 0, req_cycles = 0;
  logic [31:0] last_wr_addr = '0, last_wr_data = '0, last_rd_addr = '0;

  assign mem_bus.req_ack = mem_bus.req & ack_en;
  assign mem_bus.rdata   = mem_arr[mem_bus.addr[11:2]];
  assign mem_bus.resp    = ((mem_bus.req && ack_en && resp_en && !split) || pend)
                           ? (err_en ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK)
                           : SCR1_MEM_RESP_NOTRDY;

  always @(posedge clk) begin
    pend <= mem_bus.req && mem_bus.req_ack && split;
    if (mem_bus.req) req_cycles <= req_cycles + 1;
    if (poke_en) mem_arr[poke_addr[11:2]] <= poke_data;
    if (mem_bus.req && mem_bus.req_ack) begin
      if (mem_bus.cmd == SCR1_MEM_CMD_WR) begin
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= mem_bus.addr;
        last_wr_data <= mem_bus.wdata;
        if (!err_en) mem_arr[mem_bus.addr[11:2]] <= mem_bus.wdata;
      end else begin
        rd_cnt       <= rd_cnt + 1;
        last_rd_addr <= mem_bus.addr;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Issues one request and returns in the cycle core_resp is non-NOTRDY (or when the
  // cycle budget runs out); lat counts clock edges after the accepting cycle.
  task automatic do_req(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w,
                        input logic [31:0] a, input logic [31:0] d, output int lat);
    @(posedge clk); #1;
    core_bus.req = 1'b1; core_bus.cmd = cmd; core_bus.width = w;
    core_bus.addr = a; core_bus.wdata = d;
    #1;
    check("req_ack_idle", 32'(core_bus.req_ack), 32'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      core_bus.req = 1'b0;
    end while (core_bus.resp == SCR1_MEM_RESP_NOTRDY && lat < 40);
    core_bus.req = 1'b1;
    #1;
    check("req_ack_in_resp", 32'(core_bus.req_ack), 32'd0);
    core_bus.req = 1'b0;
  endtask

  int lat, rd0, wr0, rq0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    core_bus.req = 1'b0; core_bus.cmd = SCR1_MEM_CMD_RD; core_bus.width = SCR1_MEM_WIDTH_WORD;
    core_bus.addr = '0; core_bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ack",   32'(core_bus.req_ack), 32'd0);
    check("rst_rdata",     core_bus.rdata, 32'h0);
    check("rst_resp",      32'(core_bus.resp), 32'(SCR1_MEM_RESP_NOTRDY));
    check("rst_mem_req",   32'(mem_bus.req), 32'd0);
    check("rst_mem_cmd",   32'(mem_bus.cmd), 32'(SCR1_MEM_CMD_RD));
    check("rst_mem_addr",  mem_bus.addr, 32'h0);
    check("rst_mem_wdata", mem_bus.wdata, 32'h0);
    rst = 1'b0;

    // Word write then word read
    wr0 = wr_cnt; rd0 = rd_cnt;
    do_req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h100, 32'hDEADBEEF, lat);
    check("ww_resp", 32'(core_bus.resp), 32'(SCR1_MEM_RESP_RDY_OK));
    check("ww_lat", 32'(lat), 32'd2);
    check("ww_rdata_kept", core_bus.rdata, 32'h0);
    check("ww_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("ww_rd_count", 32'(rd_cnt - rd0), 32'd0);
    check("ww_addr", last_wr_addr, 32'h100);
    check("ww_data", last_wr_data, 32'hDEADBEEF);
    do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0, lat);
    check("wr_resp", 32'(core_bus.resp), 32'(SCR1_MEM_RESP_RDY_OK));
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_rdata", core_bus.rdata, 32'hDEADBEEF);
    check("wr_rd_addr", last_rd_addr, 32'h100);

    // Byte write as read-modify-write
    poke(32'h200, 32'h11223344);
    wr0 = wr_cnt; rd0 = rd_cnt;
    do_req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h202, 32'h000000AA, lat);
    check("bw_resp", 32'(core_bus.resp), 32'(SCR1_MEM_RESP_RDY_OK));
    check("bw_lat", 32'(lat), 32'd3);
    check("bw_rd_count", 32'(rd_cnt - rd0), 32'd1);
    check("bw_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("bw_addr", last_wr_addr, 32'h200);
    check("bw_data", last_wr_data, 32'h11AA3344);
    check("bw_rdata_kept", core_bus.rdata, 32'hDEADBEEF);

    // Sub-word reads
    poke(32'h200, 32'h11223344);
    do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h202, 32'h0, lat);
    check("hr_rdata", core_bus.rdata, 32'h00001122);
    check("hr_lat", 32'(lat), 32'd2);
    do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h203, 32'h0, lat);
    check("br3_rdata", core_bus.rdata, 32'h00000011);

    // Halfword write ignores upper wdata bits
    do_req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h200, 32'hFFFFBEEF, lat);
    check("hw_data", last_wr_data, 32'h1122BEEF);
    check("hw_lat", 32'(lat), 32'd3);
    do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h201, 32'h0, lat);
    check("br1_rdata", core_bus.rdata, 32'h000000BE);

    // Misaligned and illegal-width requests
    rq0 = req_cycles;
    do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h101, 32'h0, lat);
    check("mis_hr_resp", 32'(core_bus.resp), 32'(SCR1_MEM_RESP_RDY_ER));
    check("mis_hr_lat", 32'(lat), 32'd1);
    do_req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h102, 32'h12345678, lat);
    check("mis_ww_resp", 32'(core_bus.resp), 32'(SCR1_MEM_RESP_RDY_ER));
    check("mis_ww_lat", 32'(lat), 32'd1);
    do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_ERROR, 32'h100, 32'h0, lat);
    check("mis_err_resp", 32'(core_bus.resp), 32'(SCR1_MEM_RESP_RDY_ER));
    check("mis_no_mem_req", 32'(req_cycles - rq0), 32'd0);

    // Split response: data one cycle after accept
    poke(32'h300, 32'hA5A5A5A5);
    split = 1'b1;
    do_req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h301, 32'hFFFFFF55, lat);
    check("sp_bw_resp", 32'(core_bus.resp), 32'(SCR1_MEM_RESP_RDY_OK));
    check("sp_bw_lat", 32'(lat), 32'd5);
    check("sp_bw_data", last_wr_data, 32'hA5A555A5);
    do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h300, 32'h0, lat);
    check("sp_wr_lat", 32'(lat), 32'd3);
    check("sp_wr_rdata", core_bus.rdata, 32'hA5A555A5);
    split = 1'b0;

    // Timeout in the request phase
    ack_en = 1'b0;
    rq0 = req_cycles; rd0 = rd_cnt;
    do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h300, 32'h0, lat);
    check("tmo_req_resp", 32'(core_bus.resp), 32'(SCR1_MEM_RESP_RDY_ER));
    check("tmo_req_lat", 32'(lat), 32'd9);
    check("tmo_req_cycles", 32'(req_cycles - rq0), 32'd8);
    check("tmo_req_dropped", 32'(mem_bus.req), 32'd0);
    check("tmo_req_rdata_kept", core_bus.rdata, 32'hA5A555A5);
    ack_en = 1'b1;

    // Timeout in the response phase
    resp_en = 1'b0;
    rq0 = req_cycles;
    do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h300, 32'h0, lat);
    check("tmo_resp_resp", 32'(core_bus.resp), 32'(SCR1_MEM_RESP_RDY_ER));
    check("tmo_resp_lat", 32'(lat), 32'd10);
    check("tmo_resp_cycles", 32'(req_cycles - rq0), 32'd1);
    resp_en = 1'b1;

    // Error on the RMW read: write is never issued
    err_en = 1'b1;
    wr0 = wr_cnt;
    do_req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h200, 32'h00000077, lat);
    check("err_resp", 32'(core_bus.resp), 32'(SCR1_MEM_RESP_RDY_ER));
    check("err_lat", 32'(lat), 32'd2);
    check("err_no_write", 32'(wr_cnt - wr0), 32'd0);
    err_en = 1'b0;
    do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h200, 32'h0, lat);
    check("err_mem_intact", core_bus.rdata, 32'h1122BEEF);

    // Reset while waiting in RD_RESP
    resp_en = 1'b0;
    @(posedge clk); #1;
    core_bus.req = 1'b1; core_bus.cmd = SCR1_MEM_CMD_RD; core_bus.width = SCR1_MEM_WIDTH_WORD;
    core_bus.addr = 32'h100;
    @(posedge clk); #1;
    core_bus.req = 1'b0;
    @(posedge clk); #1;
    check("mid_in_resp_phase", 32'(mem_bus.req), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    resp_en = 1'b1;
    check("mid_rst_resp", 32'(core_bus.resp), 32'(SCR1_MEM_RESP_NOTRDY));
    check("mid_rst_mem_req", 32'(mem_bus.req), 32'd0);
    check("mid_rst_mem_cmd", 32'(mem_bus.cmd), 32'(SCR1_MEM_CMD_RD));
    check("mid_rst_mem_addr", mem_bus.addr, 32'h0);
    check("mid_rst_mem_wdata", mem_bus.wdata, 32'h0);
    check("mid_rst_rdata", core_bus.rdata, 32'h0);
    @(posedge clk); #1;
    check("mid_rst_no_resp", 32'(core_bus.resp), 32'(SCR1_MEM_RESP_NOTRDY));
    do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0, lat);
    check("post_rst_resp", 32'(core_bus.resp), 32'(SCR1_MEM_RESP_RDY_OK));
    check("post_rst_lat", 32'(lat), 32'd2);
    check("post_rst_rdata", core_bus.rdata, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
